// File: rtl/replay_ctrl_if.sv
// Bundles the replay controller's game-side inputs and BRAM/renderer-side outputs.
// The master modport is the game top level; the slave modport is replay_ctrl.
interface replay_ctrl_if #(
  parameter int ADDR_BITS = 9
);
  logic                 mode;
  logic                 endgame;
  logic                 reply;
  logic                 vga_vs;
  logic                 ram_enable;
  logic                 write_enable;
  logic [ADDR_BITS-1:0] address;
  logic                 rd_valid;
  logic                 replay_active;
  logic                 replay_done;
  logic [ADDR_BITS:0]   rec_count;

  modport master (
    output mode, endgame, reply, vga_vs,
    input  ram_enable, write_enable, address, rd_valid,
           replay_active, replay_done, rec_count
  );

  modport slave (
    input  mode, endgame, reply, vga_vs,
    output ram_enable, write_enable, address, rd_valid,
           replay_active, replay_done, rec_count
  );
endinterface

// File: rtl/replay_ctrl.sv
// replay_ctrl: sequences the pong position-record BRAM. While a game is running it
// writes one snapshot per frame slot; after game over and a replay request it reads
// the stored snapshots back, one per frame slot, for the capture renderer.
// Optional feature: define REPLAY_WRAP_EN for a circular record buffer that keeps the
// most recent 2**ADDR_BITS frames; without it recording stops once the BRAM is full.
module replay_ctrl #(
  parameter int ADDR_BITS = 9,
  parameter int FRAME_DIV = 1
) (
  input logic         CLK,
  input logic         RST_BTN_N,
  replay_ctrl_if.slave bus
);

  localparam logic [ADDR_BITS:0]   FULL_CNT = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);
  localparam logic [3:0]           DIV_LAST = 4'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECORD, S_FULL, S_ARMED, S_REPLAY, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 vs_q, vs_d;
  logic                 reply_q, reply_d;
  logic [3:0]           div_q, div_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   rec_count_q, rec_count_d;
  logic [ADDR_BITS:0]   issued_q, issued_d;
  logic                 we_q, we_d;
  logic                 re_q, re_d;
  logic                 rv_q, rv_d;
  logic [ADDR_BITS-1:0] address_q, address_d;

  logic                 frame_tick;
  logic                 slot;
  logic                 reply_rise;
  logic [ADDR_BITS-1:0] start_ptr;

  assign frame_tick = vs_q & ~bus.vga_vs;
  assign slot       = frame_tick && (div_q == DIV_LAST);
  assign reply_rise = bus.reply & ~reply_q;

`ifdef REPLAY_WRAP_EN
  // Once the buffer has wrapped, the oldest frame sits at the write pointer.
  assign start_ptr = (rec_count_q == FULL_CNT) ? wr_ptr_q : '0;
`else
  assign start_ptr = '0;
`endif

  // Next-state, pointer and BRAM-strobe logic.
  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    vs_d        = bus.vga_vs;
    reply_d     = bus.reply;
    div_d       = div_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rec_count_d = rec_count_q;
    issued_d    = issued_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    rv_d        = re_q;
    address_d   = address_q;

    if (frame_tick) div_d = (div_q == DIV_LAST) ? '0 : div_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        rec_count_d = '0;
        issued_d    = '0;
        if (bus.mode && !bus.endgame) state_d = S_RECORD;
      end
      S_RECORD: begin
        // Game over beats a coincident slot: the final frame is not stored.
        if (bus.endgame) begin
          state_d = S_ARMED;
        end else if (slot) begin
          we_d      = 1'b1;
          address_d = wr_ptr_q;
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          if (rec_count_q != FULL_CNT) rec_count_d = rec_count_q + CNT_ONE;
`ifndef REPLAY_WRAP_EN
          if (rec_count_q == FULL_CNT - CNT_ONE) state_d = S_FULL;
`endif
        end
      end
      S_FULL: begin
        if (bus.endgame) state_d = S_ARMED;
      end
      S_ARMED, S_DONE: begin
        if (state_q == S_DONE && !bus.endgame) begin
          state_d = S_IDLE;
        end else if (reply_rise) begin
          rd_ptr_d = start_ptr;
          issued_d = '0;
          state_d  = (rec_count_q == '0) ? S_DONE : S_REPLAY;
        end
      end
      S_REPLAY: begin
        if (slot && issued_q != rec_count_q) begin
          re_d      = 1'b1;
          address_d = rd_ptr_q;
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          issued_d  = issued_q + CNT_ONE;
        end else if (issued_q == rec_count_q && rv_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving the game drops everything, including a strobe about to be issued.
    if (!bus.mode) begin
      state_d     = S_IDLE;
      we_d        = 1'b0;
      re_d        = 1'b0;
      rv_d        = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      rec_count_d = '0;
      issued_d    = '0;
    end

    if (state_d != state_q) div_d = '0;
  end

  // State and datapath registers; BRAM contents live outside and survive reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RST_BTN_N) begin
    if (!RST_BTN_N) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      reply_q     <= 1'b0;
      div_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rec_count_q <= '0;
      issued_q    <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rv_q        <= 1'b0;
      address_q   <= '0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vs_d;
      reply_q     <= reply_d;
      div_q       <= div_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rec_count_q <= rec_count_d;
      issued_q    <= issued_d;
      we_q        <= we_d;
      re_q        <= re_d;
      rv_q        <= rv_d;
      address_q   <= address_d;
    end
  end

  assign bus.write_enable  = we_q;
  assign bus.ram_enable    = re_q;
  assign bus.rd_valid      = rv_q;
  assign bus.address       = address_q;
  assign bus.rec_count     = rec_count_q;
  assign bus.replay_active = (state_q == S_REPLAY);
  assign bus.replay_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_replay_ctrl.sv
// Bench for replay_ctrl: a depth-8 instance with FRAME_DIV=1 is checked through
// scoreboard queues of expected write/read addresses, plus a FRAME_DIV=2 twin that
// shares its inputs and is checked on its record count.
module tb_replay_ctrl;
  localparam int AB = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [AB-1:0] exp_wr[$];
  logic [AB-1:0] exp_rd[$];
  logic rv_pending = 1'b0;

  replay_ctrl_if #(.ADDR_BITS(AB)) bus ();
  replay_ctrl_if #(.ADDR_BITS(AB)) bus2 ();

  assign bus2.mode    = bus.mode;
  assign bus2.endgame = bus.endgame;
  assign bus2.reply   = bus.reply;
  assign bus2.vga_vs  = bus.vga_vs;

  replay_ctrl #(.ADDR_BITS(AB), .FRAME_DIV(1)) dut (
    .CLK(clk), .RST_BTN_N(rst_n), .bus(bus)
  );
  replay_ctrl #(.ADDR_BITS(AB), .FRAME_DIV(2)) dut2 (
    .CLK(clk), .RST_BTN_N(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One video frame: vsync low for 2 cycles, high for 6.
  task automatic frame();
    bus.vga_vs = 1'b0;
    cycles(2);
    bus.vga_vs = 1'b1;
    cycles(6);
  endtask

  // Scoreboard: every BRAM strobe must match the next expected address.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.write_enable === 1'b1 || bus.ram_enable === 1'b1)
        check("we_re_exclusive", 32'(bus.write_enable & bus.ram_enable), 32'd0);
      if (bus.write_enable === 1'b1) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 32'(bus.write_enable), 32'd0);
        else check("wr_addr", 32'(bus.address), 32'(exp_wr.pop_front()));
      end
      if (bus.ram_enable === 1'b1) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 32'(bus.ram_enable), 32'd0);
        else check("rd_addr", 32'(bus.address), 32'(exp_rd.pop_front()));
      end
      if (bus.rd_valid !== 1'b0 || rv_pending)
        check("rd_valid", 32'(bus.rd_valid), 32'(rv_pending));
      rv_pending = (bus.ram_enable === 1'b1);
    end else begin
      rv_pending = 1'b0;
    end
  end

  initial begin
    rst_n       = 1'b0;
    bus.mode    = 1'b0;
    bus.endgame = 1'b0;
    bus.reply   = 1'b0;
    bus.vga_vs  = 1'b1;
    cycles(3);

    // Reset state
    check("rst_we",     32'(bus.write_enable),  32'd0);
    check("rst_re",     32'(bus.ram_enable),    32'd0);
    check("rst_rv",     32'(bus.rd_valid),      32'd0);
    check("rst_addr",   32'(bus.address),       32'd0);
    check("rst_active", 32'(bus.replay_active), 32'd0);
    check("rst_done",   32'(bus.replay_done),   32'd0);
    check("rst_count",  32'(bus.rec_count),     32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Record five frames
    bus.mode = 1'b1;
    cycles(2);
    for (int i = 0; i < 5; i++) exp_wr.push_back(AB'(i));
    repeat (5) frame();
    check("rec5_count",     32'(bus.rec_count),  32'd5);
    check("rec5_div2",      32'(bus2.rec_count), 32'd2);
    check("rec5_wr_drained", 32'(exp_wr.size()), 32'd0);

    // Game over, replay five frames; a second reply rise mid-replay is ignored
    bus.endgame = 1'b1;
    cycles(2);
    check("armed_active", 32'(bus.replay_active), 32'd0);
    check("armed_done",   32'(bus.replay_done),   32'd0);
    for (int i = 0; i < 5; i++) exp_rd.push_back(AB'(i));
    bus.reply = 1'b1;
    cycles(2);
    check("replay_active", 32'(bus.replay_active), 32'd1);
    bus.reply = 1'b0;
    repeat (2) frame();
    bus.reply = 1'b1;
    cycles(1);
    bus.reply = 1'b0;
    repeat (3) frame();
    cycles(3);
    check("replay1_done",    32'(bus.replay_done),   32'd1);
    check("replay1_active",  32'(bus.replay_active), 32'd0);
    check("replay1_drained", 32'(exp_rd.size()),     32'd0);

    // Replay again from DONE with the same data
    for (int i = 0; i < 5; i++) exp_rd.push_back(AB'(i));
    bus.reply = 1'b1;
    cycles(1);
    bus.reply = 1'b0;
    repeat (5) frame();
    cycles(2);
    check("replay2_done",    32'(bus.replay_done), 32'd1);
    check("replay2_drained", 32'(exp_rd.size()),   32'd0);

    // endgame low -> IDLE -> new RECORD; slot coinciding with endgame is dropped
    bus.endgame = 1'b0;
    cycles(3);
    check("restart_count", 32'(bus.rec_count),   32'd0);
    check("restart_done",  32'(bus.replay_done), 32'd0);
    for (int i = 0; i < 4; i++) exp_wr.push_back(AB'(i));
    repeat (4) frame();
    check("rec4_count", 32'(bus.rec_count), 32'd4);
    bus.vga_vs  = 1'b0;
    bus.endgame = 1'b1;
    cycles(2);
    bus.vga_vs = 1'b1;
    cycles(4);
    check("collide_count",   32'(bus.rec_count),     32'd4);
    check("collide_drained", 32'(exp_wr.size()),     32'd0);
    check("collide_active",  32'(bus.replay_active), 32'd0);

    // Empty record: reply goes straight to DONE, no reads
    bus.mode = 1'b0;
    cycles(2);
    check("mode0_count", 32'(bus.rec_count),   32'd0);
    check("mode0_done",  32'(bus.replay_done), 32'd0);
    bus.endgame = 1'b0;
    bus.mode    = 1'b1;
    cycles(2);
    bus.endgame = 1'b1;
    cycles(2);
    bus.reply = 1'b1;
    cycles(1);
    check("empty_done",   32'(bus.replay_done),   32'd1);
    check("empty_active", 32'(bus.replay_active), 32'd0);
    bus.reply = 1'b0;
    cycles(2);
    bus.mode = 1'b0;
    cycles(2);
    check("empty_idle_done", 32'(bus.replay_done), 32'd0);

    // Overfill an 8-deep buffer with 11 frames
    bus.endgame = 1'b0;
    bus.mode    = 1'b1;
    cycles(2);
`ifdef REPLAY_WRAP_EN
    for (int i = 0; i < 11; i++) exp_wr.push_back(AB'(i % 8));
    for (int i = 0; i < 8; i++) exp_rd.push_back(AB'((i + 3) % 8));
`else
    for (int i = 0; i < 8; i++) exp_wr.push_back(AB'(i));
    for (int i = 0; i < 8; i++) exp_rd.push_back(AB'(i));
`endif
    repeat (11) frame();
    check("full_count",   32'(bus.rec_count), 32'd8);
    check("full_drained", 32'(exp_wr.size()), 32'd0);
    bus.endgame = 1'b1;
    cycles(2);
    bus.reply = 1'b1;
    cycles(1);
    bus.reply = 1'b0;
    repeat (8) frame();
    cycles(3);
    check("full_replay_done",    32'(bus.replay_done), 32'd1);
    check("full_replay_drained", 32'(exp_rd.size()),   32'd0);

    // Asynchronous reset mid-RECORD at rec_count=7
    bus.mode = 1'b0;
    cycles(2);
    bus.endgame = 1'b0;
    bus.mode    = 1'b1;
    cycles(2);
    for (int i = 0; i < 7; i++) exp_wr.push_back(AB'(i));
    repeat (7) frame();
    check("rec7_count", 32'(bus.rec_count), 32'd7);
    bus.vga_vs = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_we",     32'(bus.write_enable),  32'd0);
    check("arst_re",     32'(bus.ram_enable),    32'd0);
    check("arst_rv",     32'(bus.rd_valid),      32'd0);
    check("arst_addr",   32'(bus.address),       32'd0);
    check("arst_active", 32'(bus.replay_active), 32'd0);
    check("arst_done",   32'(bus.replay_done),   32'd0);
    check("arst_count",  32'(bus.rec_count),     32'd0);
    bus.mode   = 1'b0;
    bus.vga_vs = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check("post_rst_count",  32'(bus.rec_count), 32'd0);
    check("end_wr_drained",  32'(exp_wr.size()), 32'd0);
    check("end_rd_drained",  32'(exp_rd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
